// File: rtl/uart_pkg.sv
// Shared encodings for the serial frame checker: parity modes, FSM states
// and the expected-parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        PAR_NONE  = 3'd0,
        PAR_EVEN  = 3'd1,
        PAR_ODD   = 3'd2,
        PAR_MARK  = 3'd3,
        PAR_SPACE = 3'd4
    } parity_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_e;

    // Codes 5..7 carry no parity bit, same as PAR_NONE.
    function automatic logic has_parity(input logic [2:0] mode);
        return (mode >= 3'd1) && (mode <= 3'd4);
    endfunction

    function automatic logic expected_parity(input logic [2:0] mode, input logic acc);
        logic exp_bit;
        case (mode)
            PAR_EVEN:  exp_bit = acc;
            PAR_ODD:   exp_bit = ~acc;
            PAR_MARK:  exp_bit = 1'b1;
            PAR_SPACE: exp_bit = 1'b0;
            default:   exp_bit = 1'b0;
        endcase
        return exp_bit;
    endfunction

endpackage

// File: rtl/frame_check_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear, saturating increment or hold.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {WIDTH{1'b0}};
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= {WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/frame_check.sv
// Receive-side frame checker: collects strobed bits of one serial frame,
// checks parity and stop bits, and counts errors.
module frame_check
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8,
    localparam int LW        = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_frame_start,
    input  logic                  i_bit_valid,
    input  logic                  i_sampled_bit,
    input  logic [LW-1:0]         i_data_len,
    input  logic [2:0]            i_parity_mode,
    input  logic                  i_two_stop,
    input  logic                  i_cnt_clr,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_frame_done,
    output logic                  o_parity_err,
    output logic                  o_stop_err,
    output logic                  o_busy,
    output logic [CNT_WIDTH-1:0]  o_parity_err_cnt,
    output logic [CNT_WIDTH-1:0]  o_stop_err_cnt
);

    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] len);
        logic [LW-1:0] res;
        if (len < LW'(5)) begin
            res = LW'(5);
        end else if (len > LW'(DATA_WIDTH)) begin
            res = LW'(DATA_WIDTH);
        end else begin
            res = len;
        end
        return res;
    endfunction

    state_e                state_q;
    logic [LW-1:0]         len_q;
    logic [2:0]            mode_q;
    logic                  two_stop_q;
    logic [LW-1:0]         bit_idx_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  par_acc_q;
    logic                  par_err_q;
    logic                  stop_err_q;
    logic                  stop_cnt_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  done_q;
    logic                  perr_q;
    logic                  serr_q;

    logic stop_err_d;
    logic last_stop_d;

    assign stop_err_d  = stop_err_q | ~i_sampled_bit;
    assign last_stop_d = ~two_stop_q | stop_cnt_q;

    // Frame FSM plus registered frame results; a start pulse always restarts.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            len_q      <= LW'(DATA_WIDTH);
            mode_q     <= PAR_NONE;
            two_stop_q <= 1'b0;
            bit_idx_q  <= {LW{1'b0}};
            shift_q    <= {DATA_WIDTH{1'b0}};
            par_acc_q  <= 1'b0;
            par_err_q  <= 1'b0;
            stop_err_q <= 1'b0;
            stop_cnt_q <= 1'b0;
            data_q     <= {DATA_WIDTH{1'b0}};
            done_q     <= 1'b0;
            perr_q     <= 1'b0;
            serr_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (i_frame_start) begin
                state_q    <= ST_DATA;
                len_q      <= clamp_len(i_data_len);
                mode_q     <= i_parity_mode;
                two_stop_q <= i_two_stop;
                bit_idx_q  <= {LW{1'b0}};
                shift_q    <= {DATA_WIDTH{1'b0}};
                par_acc_q  <= 1'b0;
                par_err_q  <= 1'b0;
                stop_err_q <= 1'b0;
                stop_cnt_q <= 1'b0;
            end else if (i_bit_valid) begin
                case (state_q)
                    ST_DATA: begin
                        shift_q   <= shift_q | (DATA_WIDTH'(i_sampled_bit) << bit_idx_q);
                        par_acc_q <= par_acc_q ^ i_sampled_bit;
                        if (bit_idx_q == (len_q - LW'(1))) begin
                            state_q <= has_parity(mode_q) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + LW'(1);
                        end
                    end
                    ST_PARITY: begin
                        par_err_q <= (i_sampled_bit != expected_parity(mode_q, par_acc_q));
                        state_q   <= ST_STOP;
                    end
                    ST_STOP: begin
                        stop_err_q <= stop_err_d;
                        stop_cnt_q <= 1'b1;
                        if (last_stop_d) begin
                            state_q <= ST_IDLE;
                            data_q  <= shift_q;
                            perr_q  <= par_err_q;
                            serr_q  <= stop_err_d;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_STOP;
                        end
                    end
                    default: begin
                        state_q <= state_q;
                    end
                endcase
            end else begin
                state_q <= state_q;
            end
        end
    end

    assign o_data       = data_q;
    assign o_frame_done = done_q;
    assign o_parity_err = perr_q;
    assign o_stop_err   = serr_q;
    assign o_busy       = (state_q != ST_IDLE);

    sat_counter #(.WIDTH(CNT_WIDTH)) u_parity_cnt (
        .clk   (i_clk),
        .rst   (i_rst),
        .inc   (done_q & perr_q),
        .clr   (i_cnt_clr),
        .count (o_parity_err_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stop_cnt (
        .clk   (i_clk),
        .rst   (i_rst),
        .inc   (done_q & serr_q),
        .clr   (i_cnt_clr),
        .count (o_stop_err_cnt)
    );

endmodule

// File: tb/tb_frame_check.sv
// Directed-vector bench for frame_check: table of frames plus hand-written
// abandon, reset and counter-saturation sequences.
module tb_frame_check;

    logic       clk;
    logic       rst;
    logic       frame_start;
    logic       bit_valid;
    logic       sampled_bit;
    logic [3:0] data_len;
    logic [2:0] parity_mode;
    logic       two_stop;
    logic       cnt_clr;
    logic [7:0] data;
    logic       frame_done;
    logic       parity_err;
    logic       stop_err;
    logic       busy;
    logic [7:0] pcnt;
    logic [7:0] scnt;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int exp_pcnt = 0;
    int exp_scnt = 0;

    frame_check #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_frame_start    (frame_start),
        .i_bit_valid      (bit_valid),
        .i_sampled_bit    (sampled_bit),
        .i_data_len       (data_len),
        .i_parity_mode    (parity_mode),
        .i_two_stop       (two_stop),
        .i_cnt_clr        (cnt_clr),
        .o_data           (data),
        .o_frame_done     (frame_done),
        .o_parity_err     (parity_err),
        .o_stop_err       (stop_err),
        .o_busy           (busy),
        .o_parity_err_cnt (pcnt),
        .o_stop_err_cnt   (scnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    typedef struct {
        logic [3:0] len;
        logic [2:0] mode;
        logic       two;
        logic [7:0] din;
        int         nbits;
        logic       pbit;
        logic       s0;
        logic       s1;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_serr;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic strobe(input logic b);
        @(negedge clk);
        bit_valid   = 1'b1;
        sampled_bit = b;
        @(negedge clk);
        bit_valid   = 1'b0;
        sampled_bit = 1'b0;
    endtask

    task automatic start_pulse(input logic [3:0] len, input logic [2:0] mode,
                               input logic two, input logic with_bit);
        @(negedge clk);
        frame_start = 1'b1;
        data_len    = len;
        parity_mode = mode;
        two_stop    = two;
        bit_valid   = with_bit;
        sampled_bit = with_bit;
        @(negedge clk);
        frame_start = 1'b0;
        bit_valid   = 1'b0;
        sampled_bit = 1'b0;
        data_len    = 4'd0;
        parity_mode = 3'd0;
        two_stop    = 1'b0;
    endtask

    // Returns at the negedge inside the done cycle.
    task automatic run_frame(input logic [3:0] len, input logic [2:0] mode, input logic two,
                             input logic [7:0] din, input int nbits, input logic pbit,
                             input logic s0, input logic s1, input logic with_bit);
        logic [7:0] d;
        d = din;
        start_pulse(len, mode, two, with_bit);
        for (int i = 0; i < nbits; i++) strobe(d[i]);
        if (mode >= 3'd1 && mode <= 3'd4) strobe(pbit);
        strobe(s0);
        if (two) strobe(s1);
    endtask

    initial begin
        int d0;
        rst = 1'b1; frame_start = 1'b0; bit_valid = 1'b0; sampled_bit = 1'b0;
        data_len = 4'd0; parity_mode = 3'd0; two_stop = 1'b0; cnt_clr = 1'b0;

        //            len    mode  two   din    nb pbit  s0    s1    exp    perr  serr
        vecs[0]  = '{4'd8,  3'd1, 1'b0, 8'hA5, 8, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1]  = '{4'd8,  3'd2, 1'b0, 8'hA5, 8, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
        vecs[2]  = '{4'd5,  3'd0, 1'b1, 8'h15, 5, 1'b0, 1'b1, 1'b0, 8'h15, 1'b0, 1'b1};
        vecs[3]  = '{4'd3,  3'd0, 1'b0, 8'hFF, 5, 1'b0, 1'b1, 1'b1, 8'h1F, 1'b0, 1'b0};
        vecs[4]  = '{4'd15, 3'd3, 1'b0, 8'h3C, 8, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
        vecs[5]  = '{4'd8,  3'd3, 1'b0, 8'h81, 8, 1'b0, 1'b1, 1'b1, 8'h81, 1'b1, 1'b0};
        vecs[6]  = '{4'd8,  3'd4, 1'b0, 8'h0F, 8, 1'b1, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0};
        vecs[7]  = '{4'd6,  3'd5, 1'b0, 8'hEA, 6, 1'b0, 1'b1, 1'b1, 8'h2A, 1'b0, 1'b0};
        vecs[8]  = '{4'd7,  3'd1, 1'b1, 8'h7F, 7, 1'b1, 1'b1, 1'b1, 8'h7F, 1'b0, 1'b0};
        vecs[9]  = '{4'd8,  3'd2, 1'b0, 8'h00, 8, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[10] = '{4'd8,  3'd1, 1'b1, 8'h01, 8, 1'b1, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1};
        vecs[11] = '{4'd6,  3'd0, 1'b1, 8'h00, 6, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst data", 32'(data), 32'h0);
        chk("rst done", 32'(frame_done), 32'h0);
        chk("rst perr", 32'(parity_err), 32'h0);
        chk("rst serr", 32'(stop_err), 32'h0);
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst pcnt", 32'(pcnt), 32'h0);
        chk("rst scnt", 32'(scnt), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_frame(vecs[i].len, vecs[i].mode, vecs[i].two, vecs[i].din, vecs[i].nbits,
                      vecs[i].pbit, vecs[i].s0, vecs[i].s1, 1'b0);
            chk($sformatf("v%0d done", i), 32'(frame_done), 32'h1);
            chk($sformatf("v%0d data", i), 32'(data), 32'(vecs[i].exp_data));
            chk($sformatf("v%0d perr", i), 32'(parity_err), 32'(vecs[i].exp_perr));
            chk($sformatf("v%0d serr", i), 32'(stop_err), 32'(vecs[i].exp_serr));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'h0);
            if (vecs[i].exp_perr && exp_pcnt < 255) exp_pcnt++;
            if (vecs[i].exp_serr && exp_scnt < 255) exp_scnt++;
            @(negedge clk);
            chk($sformatf("v%0d done off", i), 32'(frame_done), 32'h0);
            chk($sformatf("v%0d data hold", i), 32'(data), 32'(vecs[i].exp_data));
            chk($sformatf("v%0d pcnt", i), 32'(pcnt), 32'(exp_pcnt));
            chk($sformatf("v%0d scnt", i), 32'(scnt), 32'(exp_scnt));
        end

        // Frame A abandoned after 3 data bits by the start of frame B.
        d0 = done_cnt;
        start_pulse(4'd8, 3'd0, 1'b0, 1'b0);
        chk("A busy", 32'(busy), 32'h1);
        strobe(1'b1); strobe(1'b1); strobe(1'b1);
        run_frame(4'd8, 3'd3, 1'b0, 8'h3C, 8, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("B data", 32'(data), 32'h3C);
        chk("B perr", 32'(parity_err), 32'h0);
        chk("B serr", 32'(stop_err), 32'h0);
        @(negedge clk);
        chk("B single done", 32'(done_cnt), 32'(d0 + 1));
        chk("B pcnt", 32'(pcnt), 32'(exp_pcnt));

        // Start and bit strobe together: the bit must be dropped.
        run_frame(4'd5, 3'd0, 1'b0, 8'h00, 5, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("D done", 32'(frame_done), 32'h1);
        chk("D data", 32'(data), 32'h00);
        @(negedge clk);

        // Reset while waiting for the parity bit.
        d0 = done_cnt;
        start_pulse(4'd8, 3'd1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) strobe(1'(i % 2));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_pcnt = 0; exp_scnt = 0;
        chk("R data", 32'(data), 32'h0);
        chk("R perr", 32'(parity_err), 32'h0);
        chk("R serr", 32'(stop_err), 32'h0);
        chk("R busy", 32'(busy), 32'h0);
        chk("R pcnt", 32'(pcnt), 32'h0);
        chk("R scnt", 32'(scnt), 32'h0);
        strobe(1'b1); strobe(1'b0); strobe(1'b1);
        chk("R idle ignores bits", 32'(busy), 32'h0);
        chk("R no done", 32'(done_cnt), 32'(d0));
        run_frame(4'd8, 3'd1, 1'b0, 8'hA5, 8, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("R next done", 32'(frame_done), 32'h1);
        chk("R next data", 32'(data), 32'hA5);
        @(negedge clk);

        // Stop-error counter saturation, then clear on an increment cycle.
        d0 = done_cnt;
        for (int n = 0; n < 256; n++) begin
            run_frame(4'd5, 3'd0, 1'b0, 8'h00, 5, 1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
        end
        chk("S frames", 32'(done_cnt), 32'(d0 + 256));
        chk("S scnt sat", 32'(scnt), 32'd255);
        chk("S pcnt", 32'(pcnt), 32'h0);
        run_frame(4'd5, 3'd0, 1'b0, 8'h00, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("S serr", 32'(stop_err), 32'h1);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        chk("S clr wins", 32'(scnt), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
